// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
// Optional BCD output path is enabled with the FREQ_BCD_OUT_EN macro.
package freq_meter_pkg;

  localparam int DEF_CNT_W      = 27;
  localparam int DEF_BCD_DIGITS = 8;
  localparam int SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2,
    ST_CONV  = 2'd3
  } meter_state_t;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } conv_state_t;

  // Double-dabble digit correction applied before each left shift.
  function automatic logic [3:0] add3_digit(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one load cycle, CNT_W shift cycles, one done cycle.
// Used by freq_gate_counter only when FREQ_BCD_OUT_EN is defined.
module bin2bcd_seq
  import freq_meter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BIT_W = $clog2(CNT_W + 1);

  conv_state_t             state_reg, state_next;
  logic [CNT_W-1:0]        shift_reg;
  logic [BIT_W-1:0]        bits_left_reg;
  logic [4*BCD_DIGITS-1:0] bcd_reg;
  logic [4*BCD_DIGITS-1:0] bcd_adj;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = add3_digit(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (!reset_n) state_reg <= CV_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CV_IDLE:  if (start) state_next = CV_SHIFT;
      CV_SHIFT: if (bits_left_reg == BIT_W'(1)) state_next = CV_DONE;
      CV_DONE:  state_next = CV_IDLE;
      default:  state_next = CV_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      shift_reg     <= '0;
      bits_left_reg <= '0;
      bcd_reg       <= '0;
    end else begin
      case (state_reg)
        CV_IDLE: begin
          if (start) begin
            shift_reg     <= bin;
            bits_left_reg <= BIT_W'(CNT_W);
            bcd_reg       <= '0;
          end
        end
        CV_SHIFT: begin
          bcd_reg       <= {bcd_adj[4*BCD_DIGITS-2:0], shift_reg[CNT_W-1]};
          shift_reg     <= shift_reg << 1;
          bits_left_reg <= bits_left_reg - BIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg != CV_IDLE);
    done = (state_reg == CV_DONE);
    bcd  = bcd_reg;
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Counts synchronized rising edges of sig_in while gate is high and reports the count on gate fall.
// Define FREQ_BCD_OUT_EN to add the sequential BCD conversion of the result on freq_bcd.
module freq_gate_counter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    sig_in,
  input  logic                    gate,
  output logic [CNT_W-1:0]        freq_value,
  output logic                    freq_ovf,
  output logic [4*BCD_DIGITS-1:0] freq_bcd,
  output logic                    valid
);

  meter_state_t           state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync3_reg;
  logic                   gate_d_reg;
  logic                   gate_low_seen_reg;
  logic [CNT_W-1:0]       count_reg;
  logic                   ovf_int_reg;
  logic [CNT_W-1:0]       freq_value_reg;
  logic                   freq_ovf_reg;
  logic                   sig_rise, gate_rise, gate_fall;
  logic                   latch_sel;

`ifdef FREQ_BCD_OUT_EN
  localparam logic [4*BCD_DIGITS-1:0] ALL_NINES = {BCD_DIGITS{4'h9}};
  logic                    conv_start, conv_busy, conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd, bcd_result, freq_bcd_reg;
`endif

  // A rise only counts once gate has been seen low after reset, so a window
  // already open at reset release is never reported.
  assign sig_rise  = sync_reg[SYNC_STAGES-1] & ~sync3_reg;
  assign gate_rise = gate & ~gate_d_reg & gate_low_seen_reg;
  assign gate_fall = ~gate & gate_d_reg;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      sync_reg          <= '0;
      sync3_reg         <= 1'b0;
      gate_d_reg        <= 1'b0;
      gate_low_seen_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      sync3_reg  <= sync_reg[SYNC_STAGES-1];
      gate_d_reg <= gate;
      if (!gate) gate_low_seen_reg <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) state_reg <= ST_WAIT;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT:  if (gate_rise) state_next = ST_COUNT;
      ST_COUNT: if (gate_fall) state_next = ST_LATCH;
`ifdef FREQ_BCD_OUT_EN
      ST_LATCH: state_next = ST_CONV;
      ST_CONV:  if (conv_done) state_next = ST_WAIT;
`else
      ST_LATCH: state_next = ST_WAIT;
`endif
      default:  state_next = ST_WAIT;
    endcase
  end

  always_comb begin
    valid     = 1'b0;
    latch_sel = 1'b0;
`ifdef FREQ_BCD_OUT_EN
    conv_start = 1'b0;
`endif
    case (state_reg)
      ST_LATCH: begin
        latch_sel = 1'b1;
`ifdef FREQ_BCD_OUT_EN
        conv_start = ~conv_busy;
`else
        valid = 1'b1;
`endif
      end
`ifdef FREQ_BCD_OUT_EN
      ST_CONV: valid = conv_done;
`endif
      default: ;
    endcase
  end

  // Overflow flags an edge that arrived while the counter was already all-ones.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      count_reg      <= '0;
      ovf_int_reg    <= 1'b0;
      freq_value_reg <= '0;
      freq_ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (gate_rise) begin
            count_reg   <= '0;
            ovf_int_reg <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (!gate_fall && sig_rise) begin
            if (&count_reg) ovf_int_reg <= 1'b1;
            else            count_reg   <= count_reg + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          freq_value_reg <= count_reg;
          freq_ovf_reg   <= ovf_int_reg;
        end
        default: ;
      endcase
    end
  end

  // The latch cycle presents the fresh count directly so it is stable while valid is high.
  assign freq_value = latch_sel ? count_reg   : freq_value_reg;
  assign freq_ovf   = latch_sel ? ovf_int_reg : freq_ovf_reg;

`ifdef FREQ_BCD_OUT_EN
  bin2bcd_seq #(
    .CNT_W      (CNT_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (count_reg),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  assign bcd_result = freq_ovf_reg ? ALL_NINES : conv_bcd;

  always_ff @(posedge sys_clk) begin
    if (!reset_n)   freq_bcd_reg <= '0;
    else if (valid) freq_bcd_reg <= bcd_result;
  end

  assign freq_bcd = valid ? bcd_result : freq_bcd_reg;
`else
  assign freq_bcd = '0;
`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// Self-checking bench for freq_gate_counter: a 27-bit and a 4-bit instance share one stimulus
// and are compared every cycle against a window-level edge-count model.
module tb_freq_gate_counter;

`ifdef FREQ_BCD_OUT_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  logic sig_in  = 1'b0;
  logic gate    = 1'b0;

  logic [26:0] fv27;
  logic        fo27, v27;
  logic [31:0] fb27;
  logic [3:0]  fv4;
  logic        fo4, v4;
  logic [7:0]  fb4;

  always #5 sys_clk = ~sys_clk;

  freq_gate_counter #(.CNT_W(27), .BCD_DIGITS(8)) dut_w27 (
    .sys_clk (sys_clk), .reset_n (reset_n), .sig_in (sig_in), .gate (gate),
    .freq_value (fv27), .freq_ovf (fo27), .freq_bcd (fb27), .valid (v27)
  );

  freq_gate_counter #(.CNT_W(4), .BCD_DIGITS(2)) dut_w4 (
    .sys_clk (sys_clk), .reset_n (reset_n), .sig_in (sig_in), .gate (gate),
    .freq_value (fv4), .freq_ovf (fo4), .freq_bcd (fb4), .valid (v4)
  );

  logic [31:0] act_val [2];
  logic [31:0] act_bcd [2];
  logic        act_ovf [2];
  logic        act_vld [2];
  assign act_val[0] = {5'b0, fv27};
  assign act_val[1] = {28'b0, fv4};
  assign act_bcd[0] = fb27;
  assign act_bcd[1] = {24'b0, fb4};
  assign act_ovf[0] = fo27;
  assign act_ovf[1] = fo4;
  assign act_vld[0] = v27;
  assign act_vld[1] = v4;

  int n_tests = 0;
  int n_fail  = 0;

  int W_K   [2] = '{27, 4};
  int MAX_K [2] = '{(1 << 27) - 1, 15};
  logic [31:0] NINES_K [2] = '{32'h9999_9999, 32'h0000_0099};

  // Window-level model state (written only by the model process).
  int  edge_n = 0;
  bit  chk_en = 1'b0;
  bit  last_edge_rst = 1'b0;
  bit  win_open [2];
  bit  pend [2];
  int  cnt [2];
  int  due [2];
  int  pval [2];

  // Checker-owned bookkeeping.
  logic [31:0] last_val [2];
  logic [31:0] last_bcd [2];
  logic        last_ovf [2];
  logic [31:0] cap_val [2];
  logic [31:0] cap_bcd [2];
  logic        cap_ovf [2];
  int          nvalid [2];

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: an edge of sig_in is seen by the counter two clocks after it is sampled;
  // a window runs strictly between the gate rising edge and gate falling edge.
  initial begin
    bit ha, hb, hc, g_prev, prev_rst, rst, rise, grise, gfall, busy;
    ha = 0; hb = 0; hc = 0; g_prev = 0; prev_rst = 1;
    for (int k = 0; k < 2; k++) begin
      win_open[k] = 0; pend[k] = 0; cnt[k] = 0; due[k] = 0; pval[k] = 0;
    end
    forever begin
      @(posedge sys_clk);
      edge_n++;
      rst   = !reset_n;
      rise  = hb & ~hc;
      grise = gate && !g_prev && !prev_rst;
      gfall = !gate && g_prev && !prev_rst;
      hc = hb;
      hb = ha;
      ha = rst ? 1'b0 : sig_in;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          win_open[k] = 0;
          pend[k]     = 0;
        end else begin
          busy = pend[k];
          if (pend[k] && edge_n == due[k] + 1) pend[k] = 0;
          if (win_open[k]) begin
            if (gfall) begin
              win_open[k] = 0;
              pend[k]     = 1;
              due[k]      = edge_n + (BCD_ON ? W_K[k] + 1 : 0);
              pval[k]     = cnt[k];
            end else if (rise) begin
              cnt[k]++;
            end
          end else if (!busy && grise) begin
            win_open[k] = 1;
            cnt[k]      = 0;
          end
        end
      end
      g_prev        = gate;
      prev_rst      = rst;
      last_edge_rst = rst;
      if (rst) chk_en = 1'b1;
    end
  end

  // Compare process: every cycle, half a clock after the active edge.
  initial begin
    bit          exp_v, eo;
    logic [31:0] ev, eb;
    for (int k = 0; k < 2; k++) begin
      last_val[k] = 0; last_bcd[k] = 0; last_ovf[k] = 0;
      cap_val[k] = 0; cap_bcd[k] = 0; cap_ovf[k] = 0; nvalid[k] = 0;
    end
    forever begin
      @(negedge sys_clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          if (last_edge_rst) begin
            last_val[k] = 0; last_ovf[k] = 0; last_bcd[k] = 0;
          end
          exp_v = pend[k] && (due[k] == edge_n);
          n_tests++;
          if (act_vld[k] !== exp_v) begin
            n_fail++;
            $display("FAIL valid dut%0d edge %0d: got %0b expected %0b", k, edge_n, act_vld[k], exp_v);
          end
          if (exp_v) begin
            eo = (pval[k] > MAX_K[k]);
            ev = eo ? 32'(MAX_K[k]) : 32'(pval[k]);
            eb = BCD_ON ? (eo ? NINES_K[k] : to_bcd(int'(ev))) : 32'h0;
            n_tests += 3;
            if (act_val[k] !== ev) begin
              n_fail++;
              $display("FAIL freq_value dut%0d: got %0d expected %0d", k, act_val[k], ev);
            end
            if (act_ovf[k] !== eo) begin
              n_fail++;
              $display("FAIL freq_ovf dut%0d: got %0b expected %0b", k, act_ovf[k], eo);
            end
            if (act_bcd[k] !== eb) begin
              n_fail++;
              $display("FAIL freq_bcd dut%0d: got %h expected %h", k, act_bcd[k], eb);
            end
            last_val[k] = ev; last_ovf[k] = eo; last_bcd[k] = eb;
            cap_val[k] = act_val[k]; cap_ovf[k] = act_ovf[k]; cap_bcd[k] = act_bcd[k];
            nvalid[k]++;
            $display("[TB] dut%0d (CNT_W=%0d) result: value=%0d ovf=%0b bcd=%h edges=%0d",
                     k, W_K[k], act_val[k], act_ovf[k], act_bcd[k], pval[k]);
          end else begin
            if (!BCD_ON) begin
              n_tests += 2;
              if (act_val[k] !== last_val[k]) begin
                n_fail++;
                $display("FAIL hold_value dut%0d: got %0d expected %0d", k, act_val[k], last_val[k]);
              end
              if (act_ovf[k] !== last_ovf[k]) begin
                n_fail++;
                $display("FAIL hold_ovf dut%0d: got %0b expected %0b", k, act_ovf[k], last_ovf[k]);
              end
            end
            n_tests++;
            if (act_bcd[k] !== last_bcd[k]) begin
              n_fail++;
              $display("FAIL hold_bcd dut%0d: got %h expected %h", k, act_bcd[k], last_bcd[k]);
            end
          end
        end
      end
    end
  end

  int ph = 0;

  task automatic step(input logic s, input logic g, input logic r);
    @(negedge sys_clk);
    sig_in  = s;
    gate    = g;
    reset_n = r;
  endtask

  function automatic logic sq(input int period);
    return ((ph % period) < (period / 2));
  endfunction

  task automatic window(input int low_n, input int high_n, input int period);
    for (int i = 0; i < low_n; i++)  begin ph++; step(sq(period), 1'b0, 1'b1); end
    for (int i = 0; i < high_n; i++) begin ph++; step(sq(period), 1'b1, 1'b1); end
  endtask

  task automatic rnd_window(input int low_n, input int high_n, input int prob);
    logic s;
    s = sig_in;
    for (int i = 0; i < low_n + high_n; i++) begin
      if ($urandom_range(99, 0) < prob) s = ~s;
      step(s, (i >= low_n), 1'b1);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    int nv0, nv1, lows, highs, prob;

    // Reset with activity on the inputs.
    for (int i = 0; i < 5; i++) step(i[0], i[1], 1'b0);
    check_lit("reset_value", int'(fv27), 0);
    check_lit("reset_ovf", int'(fo27), 0);
    check_lit("reset_bcd", int'(fb27), 0);
    check_lit("reset_valid", int'(v27) + int'(v4), 0);
    step(1'b0, 1'b0, 1'b1);

    // Basic window: period 10 for 1000 cycles.
    nv0 = nvalid[0];
    window(50, 1000, 10);
    window(60, 0, 10);
    check_lit("basic_valid_count", nvalid[0] - nv0, 1);
    check_range("basic_value", int'(cap_val[0]), 99, 101);
    check_lit("basic_ovf", int'(cap_ovf[0]), 0);
    check_lit("basic_sat_value", int'(cap_val[1]), 15);
    check_lit("basic_sat_ovf", int'(cap_ovf[1]), 1);
    if (BCD_ON) check_lit("basic_sat_bcd", int'(cap_bcd[1]), 'h99);

    // Saturation: period 4 for 200 cycles.
    window(0, 200, 4);
    window(60, 0, 4);
    check_range("sat_wide_value", int'(cap_val[0]), 49, 51);
    check_lit("sat_value", int'(cap_val[1]), 15);
    check_lit("sat_ovf", int'(cap_ovf[1]), 1);

    // Reset asserted mid-window, released with gate still high: no report.
    nv0 = nvalid[0]; nv1 = nvalid[1];
    window(20, 100, 6);
    for (int i = 0; i < 5; i++) begin ph++; step(sq(6), 1'b1, 1'b0); end
    window(0, 200, 6);
    window(60, 0, 6);
    check_lit("partial_no_valid_w27", nvalid[0] - nv0, 0);
    check_lit("partial_no_valid_w4", nvalid[1] - nv1, 0);
    window(0, 700, 7);
    window(60, 0, 7);
    check_lit("after_partial_valid", nvalid[0] - nv0, 1);
    check_range("after_partial_value", int'(cap_val[0]), 99, 101);

    // Edges landing exactly on the gate_rise and gate_fall cycles are excluded.
    for (int i = 0; i < 70; i++)
      step((i == 8 || i == 9 || i == 15 || i == 16 || i == 20 || i == 21 ||
            i == 25 || i == 26 || i == 38 || i == 39), (i >= 10 && i < 40), 1'b1);
    check_lit("boundary_value_w27", int'(cap_val[0]), 3);
    check_lit("boundary_value_w4", int'(cap_val[1]), 3);
    if (BCD_ON) check_lit("boundary_bcd", int'(cap_bcd[0]), 3);

    // Reset a few cycles after gate fall: aborts a pending conversion.
    nv0 = nvalid[0];
    window(20, 100, 5);
    window(3, 0, 5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    window(60, 0, 5);
    check_lit("reset_after_fall", nvalid[0] - nv0, BCD_ON ? 0 : 1);

    // Randomized windows.
    for (int w = 0; w < 25; w++) begin
      lows  = $urandom_range(100, 40);
      highs = $urandom_range(400, 20);
      case ($urandom_range(2, 0))
        0:       prob = 5;
        1:       prob = 20;
        default: prob = 50;
      endcase
      rnd_window(lows, highs, prob);
    end
    rnd_window(60, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
